// File: rtl/rv32_pipe_pkg.sv
// Shared definitions for the RV32 pipeline stage registers.
// Latency: n/a (constants, types and helpers only).
// Backpressure: n/a.
//
// Holds the NOP encoding used as the bubble payload, the field layout of the
// stage payload bus, and the bit positions of the side-effecting control bits.
package rv32_pipe_pkg;

  // ADDI x0, x0, 0 -- the canonical RV32 NOP, placed in the low word of a bubble
  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  // Default stage bus widths
  localparam int PIPE_DATA_WIDTH = 256;
  localparam int PIPE_CTRL_WIDTH = 8;

  // Payload field layout (LSB offset / width). The instruction word sits in the
  // low 32 bits so that a bubble payload decodes as a NOP in any later stage.
  localparam int PL_INSTR_LSB    = 0;
  localparam int PL_INSTR_W      = 32;
  localparam int PL_PC_LSB       = 32;
  localparam int PL_PC_W         = 32;
  localparam int PL_PC4_LSB      = 64;
  localparam int PL_PC4_W        = 32;
  localparam int PL_IMM_LSB      = 96;
  localparam int PL_IMM_W        = 32;
  localparam int PL_RS1_LSB      = 128;
  localparam int PL_RS1_W        = 32;
  localparam int PL_RS2_LSB      = 160;
  localparam int PL_RS2_W        = 32;
  localparam int PL_ALU_LSB      = 192;
  localparam int PL_ALU_W        = 32;
  localparam int PL_RSVD_LSB     = 224;
  localparam int PL_RSVD_W       = 32;

  // Control bit indices; every one of these triggers an architectural side effect
  localparam int CTRL_REG_WE     = 0;
  localparam int CTRL_CSR_WE     = 1;
  localparam int CTRL_MEM_WE     = 2;
  localparam int CTRL_MEM_RE     = 3;
  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_JUMP       = 5;
  localparam int CTRL_FENCE      = 6;
  localparam int CTRL_TRAP       = 7;

  // Mask of the bits that write architectural state
  localparam logic [PIPE_CTRL_WIDTH-1:0] CTRL_WE_MASK =
    PIPE_CTRL_WIDTH'((1 << CTRL_REG_WE) | (1 << CTRL_CSR_WE) | (1 << CTRL_MEM_WE));

  // Stage payload viewed as named fields
  typedef struct packed {
    logic [PL_RSVD_W-1:0]  rsvd;
    logic [PL_ALU_W-1:0]   alu;
    logic [PL_RS2_W-1:0]   rs2;
    logic [PL_RS1_W-1:0]   rs1;
    logic [PL_IMM_W-1:0]   imm;
    logic [PL_PC4_W-1:0]   pc4;
    logic [PL_PC_W-1:0]    pc;
    logic [PL_INSTR_W-1:0] instr;
  } stage_payload_t;

  // True when a control word would write any architectural state
  function automatic logic ctrl_has_write(input logic [PIPE_CTRL_WIDTH-1:0] ctrl);
    return |(ctrl & CTRL_WE_MASK);
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One storage slot (valid + payload + control) of a pipeline stage register.
// Latency: 1 cycle, load/drain/kill take effect at the next rising edge.
// Backpressure: none inside the slot; the parent decides when to load or drain.
//
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   load            capture d_data/d_ctrl and mark the slot full
//   drain           mark the slot empty, zero control, keep the payload
//   kill            mark the slot empty, zero control, payload back to BUBBLE_DATA
//   d_data, d_ctrl  incoming entry
//   q_valid, q_data, q_ctrl  stored entry
module pipe_skid_slot
  import rv32_pipe_pkg::*;
#(
  parameter int                    DATA_WIDTH  = PIPE_DATA_WIDTH,
  parameter int                    CTRL_WIDTH  = PIPE_CTRL_WIDTH,
  parameter logic [DATA_WIDTH-1:0] BUBBLE_DATA = DATA_WIDTH'(RV32_NOP)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  drain,
  input  logic                  kill,
  input  logic [DATA_WIDTH-1:0] d_data,
  input  logic [CTRL_WIDTH-1:0] d_ctrl,
  output logic                  q_valid,
  output logic [DATA_WIDTH-1:0] q_data,
  output logic [CTRL_WIDTH-1:0] q_ctrl
);

  // kill beats load beats drain. Control is zeroed whenever the slot empties
  // so an empty slot can never present a live write enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_data  <= BUBBLE_DATA;
      q_ctrl  <= '0;
    end else if (kill) begin
      q_valid <= 1'b0;
      q_data  <= BUBBLE_DATA;
      q_ctrl  <= '0;
    end else if (load) begin
      q_valid <= 1'b1;
      q_data  <= d_data;
      q_ctrl  <= d_ctrl;
    end else if (drain) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
    end
  end

endmodule

// File: rtl/pipeline_stage_register.sv
// Valid/ready pipeline stage register with flush and optional skid slot.
// Latency: 1 cycle from accepted input to m_valid when the stage is empty.
// Backpressure: SKID_EN=1 gives a registered s_ready (2 entries); SKID_EN=0 gives comb. ready.
//
// Ports:
//   clk, reset                  clock and asynchronous active-high reset
//   flush                       drop every held and same-cycle incoming entry
//   s_valid, s_ready, s_data, s_ctrl   upstream handshake and entry
//   m_valid, m_ready, m_data, m_ctrl   downstream handshake and entry (registered)
//   occupancy                   number of entries held (0..2)
module pipeline_stage_register
  import rv32_pipe_pkg::*;
#(
  parameter int                    DATA_WIDTH  = PIPE_DATA_WIDTH,
  parameter int                    CTRL_WIDTH  = PIPE_CTRL_WIDTH,
  parameter logic [DATA_WIDTH-1:0] BUBBLE_DATA = DATA_WIDTH'(RV32_NOP),
  parameter bit                    SKID_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [CTRL_WIDTH-1:0] s_ctrl,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CTRL_WIDTH-1:0] m_ctrl,
  output logic [1:0]            occupancy
);

  // Held low while reset is asserted and up to the first edge after release,
  // so nothing is handshaken into a stage that is still being cleared.
  logic                  alive;

  logic                  main_valid;
  logic                  main_load;
  logic                  main_drain;
  logic [DATA_WIDTH-1:0] main_d_data;
  logic [CTRL_WIDTH-1:0] main_d_ctrl;

  logic                  skid_valid;

  logic                  in_fire;
  logic                  out_fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
    end
  end

  // A flushed cycle never stores the incoming entry, even if it was handshaken.
  assign in_fire  = s_valid & s_ready & ~flush;
  assign out_fire = main_valid & m_ready;

  pipe_skid_slot #(
    .DATA_WIDTH  (DATA_WIDTH),
    .CTRL_WIDTH  (CTRL_WIDTH),
    .BUBBLE_DATA (BUBBLE_DATA)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .load    (main_load),
    .drain   (main_drain),
    .kill    (flush),
    .d_data  (main_d_data),
    .d_ctrl  (main_d_ctrl),
    .q_valid (main_valid),
    .q_data  (m_data),
    .q_ctrl  (m_ctrl)
  );

  generate
    if (SKID_EN) begin : g_skid
      logic                  skid_load;
      logic                  skid_drain;
      logic [DATA_WIDTH-1:0] skid_data;
      logic [CTRL_WIDTH-1:0] skid_ctrl;

      // Ready depends only on registered state, which breaks the ready chain.
      assign s_ready = alive & ~skid_valid;

      // The skid slot only ever fills while main is full, so when main
      // drains the skid entry is older than anything upstream and goes first.
      assign main_d_data = skid_valid ? skid_data : s_data;
      assign main_d_ctrl = skid_valid ? skid_ctrl : s_ctrl;

      // Refill main when it is empty or is being emptied this cycle.
      assign main_load  = out_fire ? (skid_valid | in_fire) : (~main_valid & in_fire);
      assign main_drain = out_fire & ~main_load;

      // Entry arrives while main is stalled: park it in the skid slot.
      assign skid_load  = in_fire & main_valid & ~m_ready;
      // Skid content moves into main on any downstream handshake.
      assign skid_drain = skid_valid & out_fire;

      pipe_skid_slot #(
        .DATA_WIDTH  (DATA_WIDTH),
        .CTRL_WIDTH  (CTRL_WIDTH),
        .BUBBLE_DATA (BUBBLE_DATA)
      ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (skid_load),
        .drain   (skid_drain),
        .kill    (flush),
        .d_data  (s_data),
        .d_ctrl  (s_ctrl),
        .q_valid (skid_valid),
        .q_data  (skid_data),
        .q_ctrl  (skid_ctrl)
      );
    end else begin : g_noskid
      // Single register: accept whenever the held entry leaves this cycle.
      assign s_ready     = alive & (~main_valid | m_ready);
      assign main_d_data = s_data;
      assign main_d_ctrl = s_ctrl;
      assign main_load   = in_fire;
      assign main_drain  = out_fire & ~in_fire;
      assign skid_valid  = 1'b0;
    end
  endgenerate

  assign m_valid   = main_valid;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipeline_stage_register.sv
module tb_pipeline_stage_register;

  localparam int DW = 256;
  localparam int CW = 8;
  localparam logic [DW-1:0] BUB = 256'h13;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic [CW-1:0] s_ctrl = '0;
  logic          m_ready = 1'b0;

  // a: skid build, b: single-register build
  logic          s_ready_a, m_valid_a, s_ready_b, m_valid_b;
  logic [DW-1:0] m_data_a, m_data_b;
  logic [CW-1:0] m_ctrl_a, m_ctrl_b;
  logic [1:0]    occ_a, occ_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipeline_stage_register #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .BUBBLE_DATA(BUB), .SKID_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data), .s_ctrl(s_ctrl),
    .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a), .m_ctrl(m_ctrl_a),
    .occupancy(occ_a)
  );

  pipeline_stage_register #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .BUBBLE_DATA(BUB), .SKID_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data), .s_ctrl(s_ctrl),
    .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b), .m_ctrl(m_ctrl_b),
    .occupancy(occ_b)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: one FIFO per build ----------------
  // index 1 = skid build (capacity 2, ready when fewer than 2 held),
  // index 0 = single-register build (capacity 1, ready when empty or draining).
  typedef struct packed { logic [DW-1:0] d; logic [CW-1:0] c; } ent_t;
  ent_t          mbuf  [2][4];
  int            mcnt  [2];
  logic [DW-1:0] mlast [2];
  bit            mup   [2];

  function automatic bit exp_srdy(input int k);
    if (!mup[k]) return 1'b0;
    if (k == 1) return mcnt[1] < 2;
    return (mcnt[0] == 0) || m_ready;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    bit acc [2];
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        mcnt[k] = 0; mlast[k] = BUB; mup[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) acc[k] = s_valid && exp_srdy(k) && !flush;
      for (int k = 0; k < 2; k++) begin
        if (flush) begin
          mcnt[k] = 0; mlast[k] = BUB;
        end else begin
          if (mcnt[k] > 0 && m_ready) begin
            mlast[k] = mbuf[k][0].d;
            for (int j = 0; j < 3; j++) mbuf[k][j] = mbuf[k][j+1];
            mcnt[k]--;
          end
          if (acc[k]) begin
            mbuf[k][mcnt[k]] = '{d: s_data, c: s_ctrl};
            mcnt[k]++;
          end
        end
        mup[k] = 1'b1;
      end
    end
  end

  // compare every cycle on the falling edge
  always @(negedge clk) begin
    chk("a_s_ready", s_ready_a, exp_srdy(1));
    chk("a_m_valid", m_valid_a, mcnt[1] > 0);
    chk("a_m_data",  m_data_a,  mcnt[1] > 0 ? mbuf[1][0].d : mlast[1]);
    chk("a_m_ctrl",  m_ctrl_a,  mcnt[1] > 0 ? mbuf[1][0].c : '0);
    chk("a_occ",     occ_a,     mcnt[1]);
    chk("b_s_ready", s_ready_b, exp_srdy(0));
    chk("b_m_valid", m_valid_b, mcnt[0] > 0);
    chk("b_m_data",  m_data_b,  mcnt[0] > 0 ? mbuf[0][0].d : mlast[0]);
    chk("b_m_ctrl",  m_ctrl_b,  mcnt[0] > 0 ? mbuf[0][0].c : '0);
    chk("b_occ",     occ_b,     mcnt[0]);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input bit mr, input bit fl);
    s_valid = v; s_data = d; s_ctrl = c; m_ready = mr; flush = fl;
  endtask

  initial begin
    #1 reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("init_s_ready", s_ready_a, 1);
    chk("init_occ", occ_a, 0);

    // 1: reset mid-stream with two entries held
    drive(1, 256'h11, 8'h01, 0, 0); tick();
    drive(1, 256'h22, 8'h02, 0, 0); tick();
    chk("t1_occ_full", occ_a, 2);
    drive(0, '0, '0, 0, 0);
    reset = 1'b1; #1;
    chk("t1_m_valid", m_valid_a, 0);
    chk("t1_m_ctrl", m_ctrl_a, 0);
    chk("t1_m_data_lo", m_data_a[31:0], 32'h13);
    chk("t1_occ", occ_a, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("t1_s_ready", s_ready_a, 1);

    // 2: streaming 0..15, one cycle late, no gaps
    for (int i = 0; i < 16; i++) begin
      drive(1, DW'(i), 8'h01, 1, 0); tick();
      chk("t2_m_data", m_data_a, DW'(i));
      chk("t2_m_valid", m_valid_a, 1);
      chk("t2_s_ready", s_ready_a, 1);
    end
    drive(0, '0, '0, 1, 0); tick();
    chk("t2_drained", occ_a, 0);

    // 3: backpressure A, B, C
    drive(1, 256'hA, 8'h01, 0, 0); tick();
    chk("t3_occ1", occ_a, 1);
    drive(1, 256'hB, 8'h02, 0, 0); tick();
    chk("t3_occ2", occ_a, 2);
    chk("t3_s_ready0", s_ready_a, 0);
    drive(1, 256'hC, 8'h04, 0, 0); tick();
    chk("t3_hold_A", m_data_a, 256'hA);
    chk("t3_occ2b", occ_a, 2);
    drive(1, 256'hC, 8'h04, 1, 0); tick();
    chk("t3_out_B", m_data_a, 256'hB);
    chk("t3_occ_b", occ_a, 1);
    tick();
    chk("t3_out_C", m_data_a, 256'hC);
    chk("t3_occ_c", occ_a, 1);
    drive(0, '0, '0, 1, 0); tick();
    chk("t3_occ_0", occ_a, 0);

    // 4: flush while full, entry D dropped
    drive(1, 256'hE, 8'h01, 0, 0); tick();
    drive(1, 256'hF, 8'h01, 0, 0); tick();
    chk("t4_occ2", occ_a, 2);
    drive(1, 256'hD, 8'h07, 0, 1); tick();
    chk("t4_m_valid", m_valid_a, 0);
    chk("t4_m_ctrl", m_ctrl_a, 0);
    chk("t4_occ", occ_a, 0);
    chk("t4_m_data", m_data_a, BUB);
    drive(1, 256'hD, 8'h07, 1, 1); tick();
    chk("t4_empty_flush", m_valid_a, 0);
    drive(0, '0, '0, 1, 0); tick(); tick();
    chk("t4_no_D", m_valid_a, 0);

    // 5: control gating on drain
    drive(1, 256'h5555, 8'hFF, 1, 0); tick();
    chk("t5_ctrl_ff", m_ctrl_a, 8'hFF);
    drive(0, '0, '0, 1, 0); tick();
    chk("t5_valid0", m_valid_a, 0);
    chk("t5_ctrl0", m_ctrl_a, 8'h00);
    chk("t5_data_kept", m_data_a, 256'h5555);

    // 6: single-register build, combinational ready
    drive(1, 256'h66, 8'h01, 0, 0); tick();
    chk("t6_b_valid", m_valid_b, 1);
    chk("t6_b_s_ready0", s_ready_b, 0);
    chk("t6_b_occ", occ_b, 1);
    m_ready = 1'b1; #1;
    chk("t6_b_s_ready1", s_ready_b, 1);
    drive(0, '0, '0, 1, 0); tick();

    // random valid/ready/flush against the FIFO model
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)),
            {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
            8'($urandom), ($urandom % 4) != 0, ($urandom % 64) == 0);
      tick();
      if (occ_b > 2'd1) chk("t6_b_occ_le1", occ_b, 1);
    end
    drive(0, '0, '0, 1, 0); tick(); tick(); tick();
    chk("end_empty_a", occ_a, 0);
    chk("end_empty_b", occ_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
